// File: rtl/niu_pkg.sv
// Shared definitions for the NIU receive frame buffer: stored word layout
// and the write-side state encoding.
package niu_pkg;

    // Stored word: {last, keep[7:0], data[63:0]}
    localparam int WORD_W   = 73;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 64;
    localparam int KEEP_LSB = 64;
    localparam int KEEP_W   = 8;
    localparam int LAST_BIT = 72;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2,
        ST_DROP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/niu_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module niu_sdp_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 73
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // Synchronous write and registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/niu_rx_frame_fifo.sv
// Store-and-forward receive frame buffer behind the 10GBASE-R MAC.
// Bad, oversize and non-fitting frames are dropped; only complete good
// frames become visible to the read side (via wr_commit).
//
// Write FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SYNC    | after reset: discard until a tlast to find a frame start
//   IDLE    | between frames; next beat is the first of a frame
//   RECV    | storing a frame in progress at wr_ptr
//   DROP    | frame rejected; discard beats until its tlast
module niu_rx_frame_fifo
    import niu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_WORDS  = 190
) (
    input  logic                  clk156,
    input  logic                  aresetn,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [31:0]           cnt_good,
    output logic [31:0]           cnt_bad,
    output logic [31:0]           cnt_long,
    output logic [31:0]           cnt_ovf,
    output logic [DEPTH_LOG2-1:0] fifo_level
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] BEAT_LIMIT = DEPTH_LOG2'(MAX_WORDS + 1);

    wr_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_commit_q, wr_commit_d;
    logic [DEPTH_LOG2-1:0] beat_cnt_q, beat_cnt_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]           cnt_good_q, cnt_good_d;
    logic [31:0]           cnt_bad_q, cnt_bad_d;
    logic [31:0]           cnt_long_q, cnt_long_d;
    logic [31:0]           cnt_ovf_q, cnt_ovf_d;
    logic                  tready_q;

    logic                  rd_pend_q, rd_pend_d;
    logic [WORD_W-1:0]     head_q, head_d;
    logic [WORD_W-1:0]     tail_q, tail_d;
    logic [1:0]            ocnt_q, ocnt_d;

    logic                  accept;
    logic                  full;
    logic [DEPTH_LOG2-1:0] beat_num;
    logic                  ram_we;
    logic [WORD_W-1:0]     ram_wdata;
    logic                  ram_re;
    logic [WORD_W-1:0]     ram_rdata;
    logic                  pop;
    logic [2:0]            occ;

    assign accept = s_axis_tvalid & tready_q;
    // Registered rd_ptr: a read in this cycle frees space only next cycle.
    assign full   = (wr_ptr_q + PTR_ONE) == rd_ptr_q;

    // Write FSM: store, commit or drop each accepted beat; count frame outcomes.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        beat_cnt_d  = beat_cnt_q;
        cnt_good_d  = cnt_good_q;
        cnt_bad_d   = cnt_bad_q;
        cnt_long_d  = cnt_long_q;
        cnt_ovf_d   = cnt_ovf_q;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        ram_wdata[DATA_LSB +: DATA_W] = s_axis_tdata;
        ram_wdata[KEEP_LSB +: KEEP_W] = s_axis_tkeep;
        ram_wdata[LAST_BIT]           = s_axis_tlast;
        beat_num    = (state_q == ST_IDLE) ? PTR_ONE : beat_cnt_q + PTR_ONE;

        if (accept) begin
            case (state_q)
                ST_SYNC: begin
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
                ST_IDLE, ST_RECV: begin
                    beat_cnt_d = beat_num;
                    if (full) begin
                        wr_ptr_d  = wr_commit_q;
                        cnt_ovf_d = cnt_ovf_q + 32'd1;
                        state_d   = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (beat_num == BEAT_LIMIT) begin
                        wr_ptr_d   = wr_commit_q;
                        cnt_long_d = cnt_long_q + 32'd1;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_d  = wr_commit_q;
                        cnt_bad_d = cnt_bad_q + 32'd1;
                        state_d   = ST_IDLE;
                    end else if (s_axis_tlast) begin
                        ram_we      = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE;
                        wr_commit_d = wr_ptr_q + PTR_ONE;
                        cnt_good_d  = cnt_good_q + 32'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d  = ST_RECV;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // Write-side state, pointers and counters.
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_SYNC;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            beat_cnt_q  <= '0;
            cnt_good_q  <= '0;
            cnt_bad_q   <= '0;
            cnt_long_q  <= '0;
            cnt_ovf_q   <= '0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            beat_cnt_q  <= beat_cnt_d;
            cnt_good_q  <= cnt_good_d;
            cnt_bad_q   <= cnt_bad_d;
            cnt_long_q  <= cnt_long_d;
            cnt_ovf_q   <= cnt_ovf_d;
            tready_q    <= 1'b1;
        end
    end

    niu_sdp_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk     (clk156),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    assign pop = (ocnt_q != 2'd0) & m_axis_tready;
    // Words already buffered plus the one in flight, after this cycle's pop;
    // a new read is issued only if its data is guaranteed a free slot.
    assign occ = {1'b0, ocnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};

    // Read side: issue RAM reads of committed words, fill the 2-entry prefetch.
    always_comb begin
        ram_re    = (rd_ptr_q != wr_commit_q) && (occ < 3'd2);
        rd_ptr_d  = ram_re ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rd_pend_d = ram_re;
        head_d    = head_q;
        tail_d    = tail_q;
        ocnt_d    = ocnt_q;
        case ({rd_pend_q, pop})
            2'b10: begin
                if (ocnt_q == 2'd0) head_d = ram_rdata;
                else                tail_d = ram_rdata;
                ocnt_d = ocnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                ocnt_d = ocnt_q - 2'd1;
            end
            2'b11: begin
                if (ocnt_q == 2'd1) begin
                    head_d = ram_rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    // Read pointer and prefetch registers.
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            ocnt_q    <= 2'd0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            ocnt_q    <= ocnt_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (ocnt_q != 2'd0);
    assign m_axis_tdata  = head_q[DATA_LSB +: DATA_W];
    assign m_axis_tkeep  = head_q[KEEP_LSB +: KEEP_W];
    assign m_axis_tlast  = head_q[LAST_BIT];
    assign m_axis_tuser  = 1'b0;
    assign cnt_good      = cnt_good_q;
    assign cnt_bad       = cnt_bad_q;
    assign cnt_long      = cnt_long_q;
    assign cnt_ovf       = cnt_ovf_q;
    assign fifo_level    = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_niu_rx_frame_fifo.sv
// Bench for niu_rx_frame_fifo: a default-size instance for most scenarios
// and a 64-word instance for the buffer-full scenario.
module tb_niu_rx_frame_fifo;

    logic        clk156 = 1'b0;
    logic        aresetn = 1'b0;

    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_rdy = 1'b1;
    logic [31:0] cnt_good, cnt_bad, cnt_long, cnt_ovf;
    logic [8:0]  level;

    logic [63:0] s2_tdata = '0;
    logic [7:0]  s2_tkeep = '0;
    logic        s2_tvalid = 1'b0, s2_tlast = 1'b0, s2_tuser = 1'b0;
    logic        s2_tready;
    logic [63:0] m2_tdata;
    logic [7:0]  m2_tkeep;
    logic        m2_tvalid, m2_tlast, m2_tuser;
    logic        m2_rdy = 1'b0;
    logic [31:0] c2_good, c2_bad, c2_long, c2_ovf;
    logic [5:0]  level2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          cyc = 0;
    int          first_valid_cyc = -1;
    int          last_acc_cyc = 0;
    bit          rand_done = 1'b0;
    logic [72:0] exp_q[$];
    logic [72:0] exp2_q[$];
    logic        hold_v = 1'b0;
    logic [72:0] hold_w;
    logic [72:0] mon_got, mon_exp;

    niu_rx_frame_fifo #(.DEPTH_LOG2(9), .MAX_WORDS(190)) u_dut (
        .clk156        (clk156),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_rdy),
        .cnt_good      (cnt_good),
        .cnt_bad       (cnt_bad),
        .cnt_long      (cnt_long),
        .cnt_ovf       (cnt_ovf),
        .fifo_level    (level)
    );

    niu_rx_frame_fifo #(.DEPTH_LOG2(6), .MAX_WORDS(40)) u_small (
        .clk156        (clk156),
        .aresetn       (aresetn),
        .s_axis_tdata  (s2_tdata),
        .s_axis_tkeep  (s2_tkeep),
        .s_axis_tvalid (s2_tvalid),
        .s_axis_tlast  (s2_tlast),
        .s_axis_tuser  (s2_tuser),
        .s_axis_tready (s2_tready),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tkeep  (m2_tkeep),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tlast  (m2_tlast),
        .m_axis_tuser  (m2_tuser),
        .m_axis_tready (m2_rdy),
        .cnt_good      (c2_good),
        .cnt_bad       (c2_bad),
        .cnt_long      (c2_long),
        .cnt_ovf       (c2_ovf),
        .fifo_level    (level2)
    );

    always #5 clk156 = ~clk156;
    always @(posedge clk156) cyc <= cyc + 1;

    // Output monitor for the main instance: scoreboard pop, tuser and stall-hold checks.
    always @(negedge clk156) begin
        mon_got = {m_tlast, m_tkeep, m_tdata};
        if (!aresetn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (!m_tvalid || mon_got !== hold_w) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b %h, held %h", m_tvalid, mon_got, hold_w);
                end
            end
            if (m_tvalid) begin
                n_cmp++;
                if (m_tuser !== 1'b0) begin
                    n_err++;
                    $display("FAIL m_tuser: got %0b, required 0", m_tuser);
                end
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (m_tvalid && m_rdy) begin
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_extra: got %h, none expected", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_err++;
                        $display("FAIL out_data: got %h, required %h", mon_got, mon_exp);
                    end
                end
            end
            hold_v = m_tvalid && !m_rdy;
            hold_w = mon_got;
        end
    end

    // Drive one frame on the selected instance; good frames go to its scoreboard.
    task automatic send_frame(input bit sel, input int len, input bit bad, input bit keep_it);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            l = (i == len - 1);
            k = l ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
            if (sel) begin
                s2_tdata = d; s2_tkeep = k; s2_tlast = l; s2_tuser = l & bad; s2_tvalid = 1'b1;
                if (keep_it) exp2_q.push_back({l, k, d});
            end else begin
                s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = l & bad; s_tvalid = 1'b1;
                if (keep_it) exp_q.push_back({l, k, d});
            end
            @(posedge clk156); #1;
        end
        last_acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        s_tvalid  = 1'b0;
        s2_tvalid = 1'b0;
        repeat (n) begin @(posedge clk156); #1; end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && !m_tvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk156); #1;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 64'h0 ||
            m_tkeep !== 8'h0 || m_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: tready=%0b tvalid=%0b tdata=%h tkeep=%h tlast=%0b, required all 0",
                     s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
        n_cmp++;
        if (cnt_good !== 0 || cnt_bad !== 0 || cnt_long !== 0 || cnt_ovf !== 0 || level !== 0) begin
            n_err++;
            $display("FAIL reset_counters: %0d %0d %0d %0d level %0d, required 0",
                     cnt_good, cnt_bad, cnt_long, cnt_ovf, level);
        end
        aresetn = 1'b1;
        @(posedge clk156); #1;
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL tready_after_reset: got %0b, required 1", s_tready);
        end
        // A good-looking single beat in SYNC is only a frame delimiter.
        send_frame(0, 1, 0, 0);
        idle(5);
        n_cmp++;
        if (cnt_good !== 0 || level !== 0 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL sync_discard: good=%0d level=%0d tvalid=%0b, required 0/0/0",
                     cnt_good, level, m_tvalid);
        end
    endtask

    task automatic test_back_to_back;
        int out0, fl_cyc;
        bit ok;
        m_rdy = 1'b1;
        out0 = n_out;
        first_valid_cyc = -1;
        send_frame(0, 8, 0, 1);
        fl_cyc = last_acc_cyc;
        send_frame(0, 8, 0, 1);
        send_frame(0, 8, 0, 1);
        idle(1);
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL drain_b2b: %0d beats left, required 0", exp_q.size()); end
        n_cmp++;
        if (first_valid_cyc != fl_cyc + 2) begin
            n_err++;
            $display("FAIL first_latency: valid at cycle %0d, required %0d", first_valid_cyc, fl_cyc + 2);
        end
        n_cmp++;
        if (n_out - out0 != 24) begin n_err++; $display("FAIL b2b_beats: got %0d, required 24", n_out - out0); end
        n_cmp++;
        if (cnt_good !== 32'd3) begin n_err++; $display("FAIL b2b_good: got %0d, required 3", cnt_good); end
    endtask

    task automatic test_bad_frame;
        bit ok;
        send_frame(0, 6, 0, 1);
        send_frame(0, 5, 1, 0);
        send_frame(0, 7, 0, 1);
        idle(1);
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL drain_bad: %0d beats left, required 0", exp_q.size()); end
        n_cmp++;
        if (cnt_bad !== 32'd1 || cnt_good !== 32'd5) begin
            n_err++;
            $display("FAIL bad_counts: bad=%0d good=%0d, required 1/5", cnt_bad, cnt_good);
        end
        n_cmp++;
        if (level !== 9'd0) begin n_err++; $display("FAIL bad_level: got %0d, required 0", level); end
    endtask

    task automatic test_long_frame;
        bit ok;
        send_frame(0, 200, 0, 0);
        send_frame(0, 4, 0, 1);
        idle(1);
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL drain_long: %0d beats left, required 0", exp_q.size()); end
        n_cmp++;
        if (cnt_long !== 32'd1 || cnt_good !== 32'd6 || cnt_bad !== 32'd1) begin
            n_err++;
            $display("FAIL long_counts: long=%0d good=%0d bad=%0d, required 1/6/1", cnt_long, cnt_good, cnt_bad);
        end
    endtask

    task automatic test_random_ready;
        bit ok;
        int len;
        rand_done = 1'b0;
        fork
            begin
                while (!rand_done) begin
                    m_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk156); #1;
                end
            end
        join_none
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 20);
            send_frame(0, len, 0, 1);
            idle(len + 2);
        end
        rand_done = 1'b1;
        repeat (3) @(posedge clk156);
        #2;
        m_rdy = 1'b1;
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL drain_random: %0d beats left, required 0", exp_q.size()); end
        n_cmp++;
        if (cnt_good !== 32'd106 || cnt_ovf !== 32'd0) begin
            n_err++;
            $display("FAIL random_counts: good=%0d ovf=%0d, required 106/0", cnt_good, cnt_ovf);
        end
    endtask

    task automatic test_midframe_reset;
        bit ok;
        @(posedge clk156); #1;
        m_rdy = 1'b0;
        send_frame(0, 6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
            @(posedge clk156); #1;
        end
        s_tvalid = 1'b0;
        aresetn = 1'b0;
        #13;
        aresetn = 1'b1;
        @(posedge clk156); #1;
        @(posedge clk156); #1;
        n_cmp++;
        if (cnt_good !== 0 || m_tvalid !== 1'b0 || level !== 0) begin
            n_err++;
            $display("FAIL rst_flush: good=%0d tvalid=%0b level=%0d, required 0/0/0", cnt_good, m_tvalid, level);
        end
        send_frame(0, 4, 0, 0);
        send_frame(0, 5, 0, 1);
        idle(3);
        m_rdy = 1'b1;
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL drain_rst: %0d beats left, required 0", exp_q.size()); end
        n_cmp++;
        if (cnt_good !== 32'd1 || cnt_bad !== 0 || cnt_long !== 0 || cnt_ovf !== 0) begin
            n_err++;
            $display("FAIL rst_counts: good=%0d bad=%0d long=%0d ovf=%0d, required 1/0/0/0",
                     cnt_good, cnt_bad, cnt_long, cnt_ovf);
        end
    endtask

    task automatic test_overflow;
        int beats, lasts;
        logic [72:0] got, w;
        m2_rdy = 1'b0;
        send_frame(1, 1, 0, 0);
        for (int f = 0; f < 7; f++) send_frame(1, 10, 0, f < 6);
        idle(5);
        n_cmp++;
        if (c2_ovf !== 32'd1 || c2_good !== 32'd6 || c2_bad !== 0 || c2_long !== 0) begin
            n_err++;
            $display("FAIL ovf_counts: ovf=%0d good=%0d bad=%0d long=%0d, required 1/6/0/0",
                     c2_ovf, c2_good, c2_bad, c2_long);
        end
        n_cmp++;
        if (level2 !== 6'd58) begin n_err++; $display("FAIL ovf_level: got %0d, required 58", level2); end
        m2_rdy = 1'b1;
        beats = 0;
        lasts = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk156);
            if (m2_tvalid) begin
                got = {m2_tlast, m2_tkeep, m2_tdata};
                beats++;
                if (m2_tlast) lasts++;
                n_cmp++;
                if (exp2_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ovf_extra: got %h, none expected", got);
                end else begin
                    w = exp2_q.pop_front();
                    if (got !== w || m2_tuser !== 1'b0) begin
                        n_err++;
                        $display("FAIL ovf_data: got %h user %0b, required %h user 0", got, m2_tuser, w);
                    end
                end
            end
        end
        n_cmp++;
        if (beats != 60 || lasts != 6 || level2 !== 6'd0) begin
            n_err++;
            $display("FAIL ovf_release: beats=%0d frames=%0d level=%0d, required 60/6/0", beats, lasts, level2);
        end
    endtask

    initial begin
        repeat (3) begin @(posedge clk156); #1; end
        test_reset();
        test_back_to_back();
        test_bad_frame();
        test_long_frame();
        test_random_ready();
        test_midframe_reset();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
